// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered, runtime-configurable UART transmitter with TX FIFO
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   : PARITY state and parity generator are built; i_cfg_parity_en/odd honoured
//   undefined : no parity logic; the parity config ports are accepted but ignored
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_data, i_valid       byte input, accepted when i_valid && o_ready
//   o_ready               FIFO not full (low while i_rst is high)
//   i_cfg_div             clock cycles per bit (0 treated as 1)
//   i_cfg_data_bits       00=5, 01=6, 10=7, 11=8 data bits
//   i_cfg_stop2           two stop bits
//   i_cfg_parity_en/odd   parity enable / odd parity select
//   o_uart                serial line, idles high
//   o_busy                transmitter not idle
//   o_fifo_count          FIFO occupancy
//   o_tx_done             pulse on the final cycle of each frame's last stop bit
module uart_tx_fifo #(
    parameter int CLK_FREQ_HZ = 300000000,
    parameter int DIV_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [7:0]                        i_data,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic [DIV_WIDTH-1:0]              i_cfg_div,
    input  logic [1:0]                        i_cfg_data_bits,
    input  logic                              i_cfg_stop2,
    input  logic                              i_cfg_parity_en,
    input  logic                              i_cfg_parity_odd,
    output logic                              o_uart,
    output logic                              o_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_count,
    output logic                              o_tx_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [DIV_WIDTH:0]   CNT_ONE = {{DIV_WIDTH{1'b0}}, 1'b1};
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // FIFO storage
    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    // Transmit FSM
    state_t               state_q, state_d;
    logic [DIV_WIDTH:0]   cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DIV_WIDTH:0]   bit_len;
    logic                 bit_last;
    logic                 line_d;
    logic                 done_d;

    // Frame shadow, loaded on every pop
    logic [7:0]           data_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [1:0]           nbits_q;
    logic                 stop2_q;

    logic                 uart_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 unused_ok;

`ifdef UART_TX_PARITY_EN
    logic                 par_en_q;
    logic                 par_odd_q;
    logic [7:0]           data_mask;
    logic                 par_bit;

    // Only the N transmitted bits contribute to parity.
    assign data_mask = 8'hFF >> (2'd3 - nbits_q);
    assign par_bit   = (^(data_q & data_mask)) ^ par_odd_q;
    assign unused_ok = &{1'b0, (CLK_FREQ_HZ > 0)};
`else
    assign unused_ok = &{1'b0, (CLK_FREQ_HZ > 0), i_cfg_parity_en, i_cfg_parity_odd};
`endif

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign o_ready = !full && !i_rst;
    assign push    = i_valid && o_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    // The stop phase is counted as one long bit when two stop bits are selected.
    assign bit_len  = (state_q == S_STOP && stop2_q) ? {div_q, 1'b0} : {1'b0, div_q};
    assign bit_last = (cnt_q == bit_len - CNT_ONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        idx_d   = idx_q;
        pop     = 1'b0;
        done_d  = 1'b0;
        line_d  = 1'b1;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                line_d = 1'b0;
                if (bit_last) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                line_d = data_q[idx_q];
                if (bit_last) begin
                    cnt_d = '0;
                    idx_d = idx_q + 3'd1;
                    // Last data bit index is N-1 = 4 + data_bits code.
                    if (idx_q == {1'b1, nbits_q}) begin
`ifdef UART_TX_PARITY_EN
                        state_d = par_en_q ? S_PARITY : S_STOP;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                line_d = par_bit;
                if (bit_last) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_last) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                    // Chain straight into the next start bit to avoid an idle gap.
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the current state, so the line lags the
    // state register by one cycle uniformly and every bit keeps its length.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            uart_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            uart_q  <= line_d;
            busy_q  <= (state_q != S_IDLE);
            done_q  <= done_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (pop) begin
            data_q    <= mem_q[rd_ptr_q];
            div_q     <= (i_cfg_div == '0) ? DIV_ONE : i_cfg_div;
            nbits_q   <= i_cfg_data_bits;
            stop2_q   <= i_cfg_stop2;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= i_cfg_parity_en;
            par_odd_q <= i_cfg_parity_odd;
`endif
        end
    end

    assign o_uart       = uart_q;
    assign o_busy       = busy_q;
    assign o_fifo_count = count_q;
    assign o_tx_done    = done_q;

endmodule
